multicycle_control: RTL and testbench

Multi-cycle sequencer for the CPU datapath: a Moore-style FSM that walks each instruction through fetch, decode, execute, memory and write-back. It drives every datapath mux and enable: PC, IR, memory, register file and ALU. It also keeps a two-bit status register (N, V) for the custom `ben`/`bvf` branches and waits on a memory ready handshake. The block sits between the instruction register's opcode field and the shared datapath.

---
 rtl/cpu_ctrl_pkg.sv | 55 +++++
 rtl/opcode_class.sv | 25 ++
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path:
// opcodes, FSM states and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BEN  = 6'b000110;
  localparam logic [5:0] OP_BVF  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_REX,
    S_RWB,
    S_IEX,
    S_IWB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_addi;
    logic is_beq;
    logic is_ben;
    logic is_bvf;
    logic is_j;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// One-hot classification of the IR opcode field.
// Anything not recognised lands in is_illegal.
module opcode_class
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:    cls.is_r    = 1'b1;
      OP_LW:   cls.is_lw   = 1'b1;
      OP_SW:   cls.is_sw   = 1'b1;
      OP_ADDI: cls.is_addi = 1'b1;
      OP_BEQ:  cls.is_beq  = 1'b1;
      OP_BEN:  cls.is_ben  = 1'b1;
      OP_BVF:  cls.is_bvf  = 1'b1;
      OP_J:    cls.is_j    = 1'b1;
      default: cls.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle datapath, with the
// N/V status register used by ben/bvf and a retire counter.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              opcode,
  input  logic                    mem_ready,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  input  logic                    alu_ovf,
  output logic                    pcwrite,
  output logic                    irwrite,
  output logic                    iord,
  output logic                    memread,
  output logic                    memwrite,
  output logic                    memtoreg,
  output logic                    regwrite,
  output logic                    regdst,
  output logic                    alusrca,
  output logic [1:0]              alusrcb,
  output logic [1:0]              aluop,
  output logic [1:0]              pcsource,
  output logic                    instr_retired,
  output logic                    illegal_op,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  state_t    state, next;
  op_class_t cls;
  logic      flag_n, flag_v;

  opcode_class u_cls (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_INIT;
      flag_n       <= 1'b0;
      flag_v       <= 1'b0;
      retire_count <= '0;
    end else begin
      state <= next;
      if (state == S_REX || state == S_IEX) begin
        flag_n <= alu_neg;
        flag_v <= alu_ovf;
      end
      if (instr_retired)
        retire_count <= retire_count + RETIRE_CNT_W'(1);
    end
  end

  always_comb begin
    next          = state;
    pcwrite       = 1'b0;
    irwrite       = 1'b0;
    iord          = 1'b0;
    memread       = 1'b0;
    memwrite      = 1'b0;
    memtoreg      = 1'b0;
    regwrite      = 1'b0;
    regdst        = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = SRCB_B;
    aluop         = ALU_ADD;
    pcsource      = PCS_ALU;
    instr_retired = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_INIT: next = S_FETCH;
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_4;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          next    = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        unique case (1'b1)
          cls.is_r:
            next = S_REX;
          cls.is_lw, cls.is_sw:
            next = S_MEMADR;
          cls.is_addi:
            next = S_IEX;
          cls.is_beq, cls.is_ben, cls.is_bvf:
            next = S_BRANCH;
          cls.is_j:
            next = S_JUMP;
          cls.is_illegal: begin
            illegal_op = 1'b1;
            next       = S_FETCH;
          end
          default: next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = cls.is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite      = 1'b1;
        memtoreg      = 1'b1;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          next          = S_FETCH;
        end
      end
      S_REX: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        next    = S_RWB;
      end
      S_RWB: begin
        regwrite      = 1'b1;
        regdst        = 1'b1;
        alusrca       = 1'b1;
        aluop         = ALU_FUNCT;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = S_IWB;
      end
      S_IWB: begin
        regwrite      = 1'b1;
        alusrca       = 1'b1;
        alusrcb       = SRCB_IMM;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end
      S_BRANCH: begin
        alusrca       = 1'b1;
        aluop         = ALU_SUB;
        pcsource      = PCS_ALUOUT;
        pcwrite       = (cls.is_beq & alu_zero)
                      | (cls.is_ben & flag_n)
                      | (cls.is_bvf & flag_v);
        instr_retired = 1'b1;
        next          = S_FETCH;
      end
      S_JUMP: begin
        pcsource      = PCS_JUMP;
        pcwrite       = 1'b1;
        instr_retired = 1'b1;
        next          = S_FETCH;
      end
      default: next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle
// control word and retire count against hand-built values.
module tb_multicycle_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BEN  = 6'b000110;
  localparam logic [5:0] BVF  = 6'b000101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // control word bit positions, MSB first:
  // pcw irw iord mrd mwr m2r rw rdst asa asb[2] aop[2] pcs[2] ret ill
  localparam logic [16:0] PCW  = 17'h10000;
  localparam logic [16:0] IRW  = 17'h08000;
  localparam logic [16:0] IORD = 17'h04000;
  localparam logic [16:0] MRD  = 17'h02000;
  localparam logic [16:0] MWR  = 17'h01000;
  localparam logic [16:0] M2R  = 17'h00800;
  localparam logic [16:0] RW   = 17'h00400;
  localparam logic [16:0] RDST = 17'h00200;
  localparam logic [16:0] ASA  = 17'h00100;
  localparam logic [16:0] B4   = 17'h00040;
  localparam logic [16:0] BIMM = 17'h00080;
  localparam logic [16:0] BSH  = 17'h000C0;
  localparam logic [16:0] ASUB = 17'h00010;
  localparam logic [16:0] AFN  = 17'h00020;
  localparam logic [16:0] PAO  = 17'h00004;
  localparam logic [16:0] PJ   = 17'h00008;
  localparam logic [16:0] RET  = 17'h00002;
  localparam logic [16:0] ILL  = 17'h00001;

  localparam logic [16:0] E_INIT  = 17'h0;
  localparam logic [16:0] E_FW    = MRD | B4;
  localparam logic [16:0] E_FR    = PCW | IRW | MRD | B4;
  localparam logic [16:0] E_DEC   = BSH;
  localparam logic [16:0] E_DILL  = BSH | ILL;
  localparam logic [16:0] E_MADR  = ASA | BIMM;
  localparam logic [16:0] E_MRD   = MRD | IORD;
  localparam logic [16:0] E_MWB   = RW | M2R | RET;
  localparam logic [16:0] E_MWW   = MWR | IORD;
  localparam logic [16:0] E_MWR   = MWR | IORD | RET;
  localparam logic [16:0] E_REX   = ASA | AFN;
  localparam logic [16:0] E_RWB   = RW | RDST | ASA | AFN | RET;
  localparam logic [16:0] E_IEX   = ASA | BIMM;
  localparam logic [16:0] E_IWB   = RW | ASA | BIMM | RET;
  localparam logic [16:0] E_BR0   = ASA | ASUB | PAO | RET;
  localparam logic [16:0] E_BR1   = E_BR0 | PCW;
  localparam logic [16:0] E_JMP   = PJ | PCW | RET;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        z;
    logic        n;
    logic        v;
    logic [16:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_neg = 1'b0;
  logic        alu_ovf = 1'b0;
  logic        pcwrite, irwrite, iord, memread, memwrite;
  logic        memtoreg, regwrite, regdst, alusrca;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic        instr_retired, illegal_op;
  logic [31:0] retire_count;
  logic [16:0] ctl;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_cnt = '0;
  vec_t        vt[$];

  always #5 clk = ~clk;

  multicycle_control #(.RETIRE_CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .alu_zero      (alu_zero),
    .alu_neg       (alu_neg),
    .alu_ovf       (alu_ovf),
    .pcwrite       (pcwrite),
    .irwrite       (irwrite),
    .iord          (iord),
    .memread       (memread),
    .memwrite      (memwrite),
    .memtoreg      (memtoreg),
    .regwrite      (regwrite),
    .regdst        (regdst),
    .alusrca       (alusrca),
    .alusrcb       (alusrcb),
    .aluop         (aluop),
    .pcsource      (pcsource),
    .instr_retired (instr_retired),
    .illegal_op    (illegal_op),
    .retire_count  (retire_count)
  );

  assign ctl = {pcwrite, irwrite, iord, memread, memwrite,
                memtoreg, regwrite, regdst, alusrca, alusrcb,
                aluop, pcsource, instr_retired, illegal_op};

  task automatic chk_ctl(input string nm, input logic [16:0] e);
    n_cmp++;
    if (ctl !== e) begin
      n_bad++;
      $display("FAIL %s ctl got %05h want %05h", nm, ctl, e);
    end
  endtask

  task automatic chk_cnt(input string nm);
    n_cmp++;
    if (retire_count !== model_cnt) begin
      n_bad++;
      $display("FAIL %s retire_count got %0d want %0d",
               nm, retire_count, model_cnt);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy,
                     input logic z, input logic n,
                     input logic v, input logic [16:0] e,
                     input string nm);
    vec_t r;
    r.op = op; r.rdy = rdy; r.z = z; r.n = n; r.v = v;
    r.exp = e; r.name = nm;
    vt.push_back(r);
  endtask

  // drive one cycle, check mid-cycle, advance past the edge
  task automatic step(input vec_t r);
    opcode    = r.op;
    mem_ready = r.rdy;
    alu_zero  = r.z;
    alu_neg   = r.n;
    alu_ovf   = r.v;
    @(negedge clk);
    chk_ctl(r.name, r.exp);
    chk_cnt(r.name);
    if (r.exp[1]) model_cnt = model_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    foreach (vt[i]) step(vt[i]);
    vt.delete();
  endtask

  initial begin
    // reset state
    #2;
    chk_ctl("reset_outputs", 17'h0);
    chk_cnt("reset_count");
    @(posedge clk); #1;
    reset = 1'b0;

    add(LW,  1, 0, 0, 0, E_INIT, "init");
    // lw zero-wait: 5 cycles
    add(LW,  1, 0, 0, 0, E_FR,   "lw_fetch");
    add(LW,  1, 0, 0, 0, E_DEC,  "lw_decode");
    add(LW,  1, 0, 0, 0, E_MADR, "lw_memadr");
    add(LW,  1, 0, 0, 0, E_MRD,  "lw_memrd");
    add(LW,  1, 0, 0, 0, E_MWB,  "lw_memwb");
    // sw with fetch wait and 3 MEMWR wait cycles
    add(SW,  0, 0, 0, 0, E_FW,   "sw_fetch_wait");
    add(SW,  1, 0, 0, 0, E_FR,   "sw_fetch");
    add(SW,  1, 0, 0, 0, E_DEC,  "sw_decode");
    add(SW,  1, 0, 0, 0, E_MADR, "sw_memadr");
    add(SW,  0, 0, 0, 0, E_MWW,  "sw_wait1");
    add(SW,  0, 0, 0, 0, E_MWW,  "sw_wait2");
    add(SW,  0, 0, 0, 0, E_MWW,  "sw_wait3");
    add(SW,  1, 0, 0, 0, E_MWR,  "sw_memwr");
    // lw with a memory wait in MEMRD
    add(LW,  1, 0, 0, 0, E_FR,   "lw2_fetch");
    add(LW,  1, 0, 0, 0, E_DEC,  "lw2_decode");
    add(LW,  1, 0, 0, 0, E_MADR, "lw2_memadr");
    add(LW,  0, 0, 0, 0, E_MRD,  "lw2_memrd_wait");
    add(LW,  1, 0, 0, 0, E_MRD,  "lw2_memrd");
    add(LW,  1, 0, 0, 0, E_MWB,  "lw2_memwb");
    // add overflowing, then bvf taken
    add(RT,  1, 0, 0, 0, E_FR,   "add_fetch");
    add(RT,  1, 0, 0, 0, E_DEC,  "add_decode");
    add(RT,  1, 0, 1, 1, E_REX,  "add_rex");
    add(RT,  1, 0, 0, 0, E_RWB,  "add_rwb");
    add(BVF, 1, 0, 0, 0, E_FR,   "bvf1_fetch");
    add(BVF, 1, 0, 0, 0, E_DEC,  "bvf1_decode");
    add(BVF, 1, 0, 0, 0, E_BR1,  "bvf1_taken");
    // addi without overflow, then bvf not taken
    add(ADDI,1, 0, 0, 0, E_FR,   "addi_fetch");
    add(ADDI,1, 0, 0, 0, E_DEC,  "addi_decode");
    add(ADDI,1, 0, 0, 0, E_IEX,  "addi_iex");
    add(ADDI,1, 0, 1, 1, E_IWB,  "addi_iwb");
    add(BVF, 1, 0, 0, 0, E_FR,   "bvf2_fetch");
    add(BVF, 1, 0, 0, 0, E_DEC,  "bvf2_decode");
    add(BVF, 1, 1, 1, 1, E_BR0,  "bvf2_not_taken");
    // beq taken / not taken on alu_zero
    add(BEQ, 1, 0, 0, 0, E_FR,   "beq1_fetch");
    add(BEQ, 1, 0, 0, 0, E_DEC,  "beq1_decode");
    add(BEQ, 1, 1, 0, 0, E_BR1,  "beq1_taken");
    add(BEQ, 1, 0, 0, 0, E_FR,   "beq0_fetch");
    add(BEQ, 1, 0, 0, 0, E_DEC,  "beq0_decode");
    add(BEQ, 1, 0, 1, 1, E_BR0,  "beq0_not_taken");
    // R-type negative, lw in between, ben still taken
    add(RT,  1, 0, 0, 0, E_FR,   "sub_fetch");
    add(RT,  1, 0, 0, 0, E_DEC,  "sub_decode");
    add(RT,  1, 0, 1, 0, E_REX,  "sub_rex");
    add(RT,  1, 0, 0, 0, E_RWB,  "sub_rwb");
    add(LW,  1, 0, 0, 0, E_FR,   "lw3_fetch");
    add(LW,  1, 0, 0, 0, E_DEC,  "lw3_decode");
    add(LW,  1, 0, 0, 0, E_MADR, "lw3_memadr");
    add(LW,  1, 0, 0, 0, E_MRD,  "lw3_memrd");
    add(LW,  1, 0, 0, 0, E_MWB,  "lw3_memwb");
    add(BEN, 1, 0, 0, 0, E_FR,   "ben_fetch");
    add(BEN, 1, 0, 0, 0, E_DEC,  "ben_decode");
    add(BEN, 1, 0, 0, 0, E_BR1,  "ben_taken");
    // bvf after that sub: flag_v is 0
    add(BVF, 1, 0, 0, 0, E_FR,   "bvf3_fetch");
    add(BVF, 1, 0, 0, 0, E_DEC,  "bvf3_decode");
    add(BVF, 1, 0, 0, 0, E_BR0,  "bvf3_not_taken");
    // illegal opcode: 2 cycles, no retire
    add(BAD, 1, 0, 0, 0, E_FR,   "ill_fetch");
    add(BAD, 1, 0, 0, 0, E_DILL, "ill_decode");
    // jump: 3 cycles
    add(JMP, 1, 0, 0, 0, E_FR,   "j_fetch");
    add(JMP, 1, 0, 0, 0, E_DEC,  "j_decode");
    add(JMP, 1, 0, 0, 0, E_JMP,  "j_jump");
    // set both flags before the reset test
    add(RT,  1, 0, 0, 0, E_FR,   "r2_fetch");
    add(RT,  1, 0, 0, 0, E_DEC,  "r2_decode");
    add(RT,  1, 0, 1, 1, E_REX,  "r2_rex");
    add(RT,  1, 0, 0, 0, E_RWB,  "r2_rwb");
    add(SW,  1, 0, 0, 0, E_FR,   "sw2_fetch");
    add(SW,  1, 0, 0, 0, E_DEC,  "sw2_decode");
    add(SW,  1, 0, 0, 0, E_MADR, "sw2_memadr");
    run_table();

    // asynchronous reset in the middle of a MEMWR wait
    opcode = SW;
    mem_ready = 1'b0;
    #1;
    chk_ctl("memwr_before_reset", E_MWW);
    reset = 1'b1;
    #1;
    chk_ctl("memwr_async_reset", 17'h0);
    model_cnt = '0;
    chk_cnt("count_async_reset");
    @(posedge clk); #1;
    chk_ctl("held_in_reset", 17'h0);
    reset = 1'b0;

    // INIT for one cycle, then fetch; flags were cleared
    add(BEN, 1, 0, 0, 0, E_INIT, "post_init");
    add(BEN, 1, 0, 0, 0, E_FR,   "post_ben_fetch");
    add(BEN, 1, 0, 0, 0, E_DEC,  "post_ben_decode");
    add(BEN, 1, 0, 0, 0, E_BR0,  "post_ben_flag_n0");
    add(BVF, 1, 0, 0, 0, E_FR,   "post_bvf_fetch");
    add(BVF, 1, 0, 0, 0, E_DEC,  "post_bvf_decode");
    add(BVF, 1, 0, 0, 0, E_BR0,  "post_bvf_flag_v0");
    add(JMP, 1, 0, 0, 0, E_FR,   "post_fetch");
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
